vga_scan_reader: RTL and testbench

- Read side of the pixel framebuffer. The game logic writes the framebuffer through the x/y/colour/plot interface.
- This block generates 640x480@60 VGA timing from the 50 MHz system clock.
- It reads the 320x240, 3-bit-per-pixel framebuffer through a synchronous-read port. Each stored pixel is shown as a 2x2 block.
- It drives the DAC-side VGA pins and gives the game a frame-start pulse and a vblank flag, so drawing can be synchronised to frames.

---
 rtl/vga_scan_reader.sv | 137 +++++++++++++
 tb/tb_vga_scan_reader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_reader.sv
// VGA 640x480@60 scan-out for a 320x240x3 framebuffer, each stored pixel shown as a 2x2 block.
// Pin outputs lag the h/v counters by two pixel ticks: address stage, then colour/sync stage.
module vga_scan_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int FB_W   = 320
) (
  input  logic        clock,
  input  logic        reset,
  output logic [16:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        frame_start,
  output logic        vblank
);

  localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0] H_SSTART_C = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SEND_C   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
  localparam logic [9:0] V_SSTART_C = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SEND_C   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [8:0] FB_W_C     = 9'(FB_W);

  logic        r_phase;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [16:0] r_rdAddr;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_vis1;
  logic        r_hsOut;
  logic        r_vsOut;
  logic        r_blankN;
  logic [9:0]  r_red;
  logic [9:0]  r_green;
  logic [9:0]  r_blue;
  logic        r_frameStart;

  logic        w_pixEn;
  logic        w_hWrap;
  logic        w_vWrap;
  logic        w_vis0;
  logic [8:0]  w_col;
  logic [16:0] w_row;
  logic [16:0] w_addr;
  logic        w_hs0;
  logic        w_vs0;

  assign w_pixEn = r_phase;
  assign w_hWrap = (r_h == H_LAST_C);
  assign w_vWrap = (r_v == V_LAST_C);
  assign w_col   = r_h[9:1];

  // The column guard keeps a wide visible area from spilling into the next framebuffer row.
  assign w_vis0  = (r_h < H_VIS_C) && (r_v < V_VIS_C) && (w_col < FB_W_C);

  // Row base is (v/2)*320 built from two shifts instead of a multiplier.
  assign w_row   = ({8'd0, r_v[9:1]} << 8) + ({8'd0, r_v[9:1]} << 6);
  assign w_addr  = w_row + {8'd0, w_col};

  assign w_hs0   = !((r_h >= H_SSTART_C) && (r_h < H_SEND_C));
  assign w_vs0   = !((r_v >= V_SSTART_C) && (r_v < V_SEND_C));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase      <= 1'b0;
      r_h          <= 10'd0;
      r_v          <= 10'd0;
      r_rdAddr     <= 17'd0;
      r_hs1        <= 1'b1;
      r_vs1        <= 1'b1;
      r_vis1       <= 1'b0;
      r_hsOut      <= 1'b1;
      r_vsOut      <= 1'b1;
      r_blankN     <= 1'b0;
      r_red        <= 10'd0;
      r_green      <= 10'd0;
      r_blue       <= 10'd0;
      r_frameStart <= 1'b0;
    end else begin
      r_phase      <= ~r_phase;
      r_frameStart <= 1'b0;
      if (w_pixEn) begin
        if (w_hWrap) begin
          r_h <= 10'd0;
          r_v <= w_vWrap ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end

        r_rdAddr <= w_vis0 ? w_addr : 17'd0;
        r_hs1    <= w_hs0;
        r_vs1    <= w_vs0;
        r_vis1   <= w_vis0;

        // rd_data has had a full clock to settle since the address moved one tick ago.
        r_hsOut  <= r_hs1;
        r_vsOut  <= r_vs1;
        r_blankN <= r_vis1;
        r_red    <= (r_vis1 && rd_data[2]) ? 10'h3FF : 10'h000;
        r_green  <= (r_vis1 && rd_data[1]) ? 10'h3FF : 10'h000;
        r_blue   <= (r_vis1 && rd_data[0]) ? 10'h3FF : 10'h000;

        r_frameStart <= w_hWrap && w_vWrap;
      end
    end
  end

  assign rd_addr     = r_rdAddr;
  assign VGA_CLK     = r_phase;
  assign VGA_HS      = r_hsOut;
  assign VGA_VS      = r_vsOut;
  assign VGA_BLANK_N = r_blankN;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_red;
  assign VGA_G       = r_green;
  assign VGA_B       = r_blue;
  assign frame_start = r_frameStart;
  assign vblank      = (r_v >= V_VIS_C);

endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench for vga_scan_reader: a full-size instance for line timing, addressing and colour,
// and a shrunken-timing instance so whole frames fit in a short run.
module tb_vga_scan_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  rdData;
  logic [16:0] rdAddr;
  logic        vgaClk, vgaHs, vgaVs, vgaBlankN, vgaSyncN, frameStart, vblank;
  logic [9:0]  vgaR, vgaG, vgaB;

  logic [2:0]  sRdData;
  logic [16:0] sRdAddr;
  logic        sVgaClk, sVgaHs, sVgaVs, sBlankN, sSyncN, sFrameStart, sVblank;
  logic [9:0]  sR, sG, sB;

  int total = 0;
  int bad = 0;
  int k = 0;
  int seg = 0;
  int hsLowCnt = 0;
  int hsFirst = -1;
  int sVsLow = 0;
  int sVblankCnt = 0;
  int sFsCnt = 0;
  int sFsFirst = -1;
  int dFsCnt = 0;

  always #10 clock = ~clock;

  vga_scan_reader dut (
    .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdData),
    .VGA_CLK(vgaClk), .VGA_HS(vgaHs), .VGA_VS(vgaVs), .VGA_BLANK_N(vgaBlankN),
    .VGA_SYNC_N(vgaSyncN), .VGA_R(vgaR), .VGA_G(vgaG), .VGA_B(vgaB),
    .frame_start(frameStart), .vblank(vblank)
  );

  // 24 ticks per line, 15 lines per frame: 360 ticks = 720 clocks per frame.
  vga_scan_reader #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .FB_W(320)
  ) dutSmall (
    .clock(clock), .reset(reset), .rd_addr(sRdAddr), .rd_data(sRdData),
    .VGA_CLK(sVgaClk), .VGA_HS(sVgaHs), .VGA_VS(sVgaVs), .VGA_BLANK_N(sBlankN),
    .VGA_SYNC_N(sSyncN), .VGA_R(sR), .VGA_G(sG), .VGA_B(sB),
    .frame_start(sFrameStart), .vblank(sVblank)
  );

  // Framebuffer model: address 0 reads white, anything else reads its low three address bits.
  function automatic logic [2:0] ramColour(input logic [16:0] a);
    ramColour = (a == 17'd0) ? 3'b111 : a[2:0];
  endfunction

  always @(posedge clock) rdData <= ramColour(rdAddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (k=%0d)", tag, observed, expected, k);
    end
  endtask

  // One clock edge, sampled 1 ns later, with running tallies for the windowed checks.
  task automatic tick();
    @(posedge clock);
    #1;
    k++;
    if (seg == 1) begin
      if (k <= 1600 && !vgaHs) begin
        hsLowCnt++;
        if (hsFirst < 0) hsFirst = k;
      end
      if (k <= 720) begin
        if (!sVgaVs) sVsLow++;
        if (sVblank) sVblankCnt++;
      end
      if (k <= 1440 && sFrameStart) begin
        sFsCnt++;
        if (sFsFirst < 0) sFsFirst = k;
      end
    end
    if (frameStart) dFsCnt++;
  endtask

  task automatic applyStimulus(input logic rst, input int cycles);
    reset = rst;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic runTo(input int target);
    while (k < target) tick();
  endtask

  task automatic checkResetState(input string where);
    checkOutput({where, "_clk"}, 32'(vgaClk), 32'd0);
    checkOutput({where, "_hs"}, 32'(vgaHs), 32'd1);
    checkOutput({where, "_vs"}, 32'(vgaVs), 32'd1);
    checkOutput({where, "_blank"}, 32'(vgaBlankN), 32'd0);
    checkOutput({where, "_r"}, 32'(vgaR), 32'd0);
    checkOutput({where, "_g"}, 32'(vgaG), 32'd0);
    checkOutput({where, "_b"}, 32'(vgaB), 32'd0);
    checkOutput({where, "_addr"}, 32'(rdAddr), 32'd0);
    checkOutput({where, "_fs"}, 32'(frameStart), 32'd0);
    checkOutput({where, "_vblank"}, 32'(vblank), 32'd0);
  endtask

  task automatic checkPixel(input string tag, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                            input logic blankN);
    checkOutput({tag, "_r"}, 32'(vgaR), 32'(r));
    checkOutput({tag, "_g"}, 32'(vgaG), 32'(g));
    checkOutput({tag, "_b"}, 32'(vgaB), 32'(b));
    checkOutput({tag, "_blank"}, 32'(vgaBlankN), 32'(blankN));
  endtask

  initial begin
    sRdData = 3'b000;
    applyStimulus(1'b1, 3);
    checkResetState("rst");
    checkOutput("rst_syncn", 32'(vgaSyncN), 32'd0);

    // k counts edges since reset release; the counters stand at tick k/2 and pins show tick k/2-2.
    reset = 1'b0;
    k = 0;
    seg = 1;
    tick();
    checkOutput("rel_clk1", 32'(vgaClk), 32'd1);
    runTo(2);
    checkOutput("rel_clk2", 32'(vgaClk), 32'd0);
    checkOutput("rel_blank2", 32'(vgaBlankN), 32'd0);
    runTo(3);
    checkOutput("rel_blank3", 32'(vgaBlankN), 32'd0);
    checkOutput("rel_hs3", 32'(vgaHs), 32'd1);
    runTo(4);
    checkPixel("px_h0v0", 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
    runTo(16);
    checkPixel("px_h6v0", 10'h000, 10'h3FF, 10'h3FF, 1'b1);
    runTo(24);
    checkPixel("px_h10v0", 10'h3FF, 10'h000, 10'h3FF, 1'b1);
    runTo(1404);
    checkPixel("px_h700_blanked", 10'h000, 10'h000, 10'h000, 1'b0);

    runTo(1600);
    checkOutput("hs_low_clocks", 32'(hsLowCnt), 32'd192);
    checkOutput("hs_first_k", 32'(hsFirst), 32'd1316);
    checkOutput("s_fs_count", 32'(sFsCnt), 32'd2);
    checkOutput("s_fs_first_k", 32'(sFsFirst), 32'd720);
    checkOutput("s_vs_low_clocks", 32'(sVsLow), 32'd96);
    checkOutput("s_vblank_clocks", 32'(sVblankCnt), 32'd336);

    runTo(2915);
    checkOutput("hs_line1_before", 32'(vgaHs), 32'd1);
    runTo(2916);
    checkOutput("hs_line1_start", 32'(vgaHs), 32'd0);
    runTo(3208);
    checkPixel("px_h2v2", 10'h000, 10'h000, 10'h3FF, 1'b1);

    runTo(8008);
    checkOutput("addr_h3v5", 32'(rdAddr), 32'd641);
    checkOutput("vblank_v5", 32'(vblank), 32'd0);
    runTo(9280);
    checkOutput("addr_h639v5", 32'(rdAddr), 32'd959);
    runTo(9282);
    checkOutput("addr_h640v5", 32'(rdAddr), 32'd0);

    // One-clock reset mid-line at h=400, v=6, with the visible pixel on the pins.
    runTo(10400);
    checkOutput("pre_rst_blank", 32'(vgaBlankN), 32'd1);
    applyStimulus(1'b1, 1);
    checkResetState("midrst");
    reset = 1'b0;
    k = 0;
    seg = 2;
    runTo(3);
    checkOutput("post_blank3", 32'(vgaBlankN), 32'd0);
    runTo(4);
    checkOutput("post_blank4", 32'(vgaBlankN), 32'd1);
    runTo(1315);
    checkOutput("post_hs_before", 32'(vgaHs), 32'd1);
    runTo(1316);
    checkOutput("post_hs_start", 32'(vgaHs), 32'd0);

    checkOutput("d_no_frame_start", 32'(dFsCnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
